dct_module: RTL

DCT_MODULE -- requirements
Module: dct_module

---
 rtl/dct_module.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dct_module.sv
// Cepstral DCT engine: buffers N_MEL log-mel samples per frame, then MACs them against
// a programmable Q15 cosine table, emitting N_MFCC saturated Q11 coefficients in order.
module dct_module #(
  parameter int N_MEL  = 16,
  parameter int N_MFCC = 13
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [15:0]                log_in,
  input  logic                              log_valid,
  input  logic                              coef_we,
  input  logic [$clog2(N_MFCC*N_MEL)-1:0]   coef_addr,
  input  logic signed [15:0]                coef_wdata,
  output logic signed [15:0]                mfcc_out,
  output logic                              mfcc_valid,
  output logic [$clog2(N_MFCC)-1:0]         mfcc_idx,
  output logic                              frame_done,
  output logic                              busy,
  output logic                              overflow_err
);
  localparam int COEF_N = N_MFCC * N_MEL;
  localparam int AW     = $clog2(COEF_N);
  localparam int NW     = $clog2(N_MEL);
  localparam int KW     = $clog2(N_MFCC);
  localparam int ACCW   = 32 + NW + 1;
  localparam logic [NW-1:0]          N_LAST  = NW'(N_MEL - 1);
  localparam logic [KW-1:0]          K_LAST  = KW'(N_MFCC - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;
  state_t state, next_state;

  logic signed [15:0] in_buf   [N_MEL];
  logic signed [15:0] cmp_buf  [N_MEL];
  logic signed [15:0] coef_mem [COEF_N];

  logic [NW-1:0]          wr_idx;
  logic [NW-1:0]          n;
  logic [KW-1:0]          k;
  logic [AW-1:0]          cptr;
  logic signed [31:0]     prod;
  logic signed [ACCW-1:0] acc, acc_next, acc_sh;
  logic signed [15:0]     sat_val;
  logic                   last_sample, start, coef_ok;

  assign last_sample = log_valid && (wr_idx == N_LAST);
  assign start       = last_sample && !busy;
  assign coef_ok     = ({1'b0, coef_addr} < (AW+1)'(COEF_N));

  // Coefficients are stored row-major (k*N_MEL+n), so a single running pointer walks them.
  assign prod     = cmp_buf[n] * coef_mem[cptr];
  assign acc_next = acc + ACCW'(prod);
  assign acc_sh   = acc_next >>> 15;

  always_comb begin
    sat_val = acc_sh[15:0];
    if (acc_sh > SAT_MAX)      sat_val = 16'sh7fff;
    else if (acc_sh < SAT_MIN) sat_val = 16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) next_state = MAC;
      MAC:     if (n == N_LAST) next_state = EMIT;
      EMIT:    next_state = (k == K_LAST) ? IDLE : MAC;
      default: next_state = IDLE;
    endcase
  end

  // Buffers and coefficient table carry no reset; the table must survive rst.
  always_ff @(posedge clk) begin
    if (!rst && log_valid) begin
      in_buf[wr_idx] <= log_in;
      if (start) begin
        for (int i = 0; i < N_MEL; i++)
          cmp_buf[i] <= (i == N_MEL - 1) ? log_in : in_buf[i];
      end
    end
    if (!rst && coef_we && !busy && coef_ok)
      coef_mem[coef_addr] <= coef_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx       <= '0;
      n            <= '0;
      k            <= '0;
      cptr         <= '0;
      acc          <= '0;
      mfcc_out     <= '0;
      mfcc_idx     <= '0;
      mfcc_valid   <= 1'b0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      mfcc_valid <= 1'b0;
      frame_done <= 1'b0;
      if (log_valid)
        wr_idx <= (wr_idx == N_LAST) ? '0 : wr_idx + 1'b1;
      if (last_sample && busy)
        overflow_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            n    <= '0;
            k    <= '0;
            cptr <= '0;
            acc  <= '0;
          end
        end
        MAC: begin
          acc  <= acc_next;
          cptr <= cptr + 1'b1;
          n    <= (n == N_LAST) ? '0 : n + 1'b1;
          // Outputs register on the final MAC so the pulse lands in the EMIT cycle.
          if (n == N_LAST) begin
            mfcc_out   <= sat_val;
            mfcc_idx   <= k;
            mfcc_valid <= 1'b1;
            frame_done <= (k == K_LAST);
          end
        end
        EMIT: begin
          acc <= '0;
          if (k != K_LAST) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
